// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Memory-side responder for the core's instruction-fetch handshake. One fetch
// address can be accepted per cycle. After a fixed LATENCY the FETCH_WIDTH
// consecutive instruction words starting at that address are pushed into a
// response queue. The core drains the queue at its own pace. An occupancy
// counter reserves a queue slot for every accepted fetch, so the queue can
// never overflow while the core stalls its receive side.
//
// The backing store is a plain register array. Its contents are written
// through the load port, which is used for bench or boot preload.
//
// Ports:
//   clk              clock
//   rst              asynchronous, active-low reset
//   imem_req_rdy     responder can accept a fetch
//   imem_req_val     core presents a fetch address
//   imem_req_packet  byte address of lane 0 (addr[1:0] ignored)
//   imem_rec_rdy     core can take a response
//   imem_rec_val     response valid (head of the response queue)
//   imem_rec_packet  lane i in bits [32i+31:32i]
//   imem_rec_err     out-of-range fetch flag (only with IMEM_OOB_ERR_EN)
//   flush            discard all in-flight and queued fetches
//   load_we          backing-store write enable
//   load_addr        byte address of the word to write
//   load_data        word to write
//
// Optional feature macro: IMEM_OOB_ERR_EN
//   When it is defined, any lane whose word address is past the end of the
//   store returns a NOP instead of wrapping, and the response carries
//   imem_rec_err=1.
//   When it is undefined, lane addresses wrap modulo DEPTH_WORDS.
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int FETCH_WIDTH   = 2,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 imem_req_rdy,
  input  logic                                 imem_req_val,
  input  logic [CPU_ADDR_BITS-1:0]             imem_req_packet,
  input  logic                                 imem_rec_rdy,
  output logic                                 imem_rec_val,
  output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] imem_rec_packet,
`ifdef IMEM_OOB_ERR_EN
  output logic                                 imem_rec_err,
`endif
  input  logic                                 flush,
  input  logic                                 load_we,
  input  logic [CPU_ADDR_BITS-1:0]             load_addr,
  input  logic [CPU_INST_BITS-1:0]             load_data
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  // Number of registers between acceptance and the queue push edge
  // (LATENCY=1 pushes on the acceptance edge itself).
  localparam int PD  = (LATENCY > 1) ? (LATENCY - 1) : 1;
  localparam int QPW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int DW  = FETCH_WIDTH * CPU_INST_BITS;

  // Advance a queue pointer, wrapping at QUEUE_DEPTH (not a power-of-two
  // assumption on the pointer width when QUEUE_DEPTH=1).
  function automatic logic [QPW-1:0] ptr_inc(input logic [QPW-1:0] p);
    if (p == QPW'(QUEUE_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + QPW'(1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [CPU_INST_BITS-1:0] mem_q [DEPTH_WORDS];

  logic [CW-1:0]          occ_q, occ_d;
  logic [PD-1:0]          pipe_vld_q, pipe_vld_d;
  logic [PD-1:0][AW-1:0]  pipe_idx_q, pipe_idx_d;

  logic [QUEUE_DEPTH-1:0][DW-1:0] q_data_q, q_data_d;
  logic [QPW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [QPW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          q_cnt_q, q_cnt_d;

  logic                   fire_req_s;
  logic                   fire_rec_s;
  logic [AW-1:0]          req_idx_s;
  logic                   push_vld_s;
  logic [AW-1:0]          push_idx_s;
  logic                   push_s;
  logic [DW-1:0]          rd_data_s;

`ifdef IMEM_OOB_ERR_EN
  localparam logic [CPU_INST_BITS-1:0] NOP_INST = CPU_INST_BITS'(32'h0000_0013);
  logic [FETCH_WIDTH-1:0]          req_oob_s;
  logic [FETCH_WIDTH-1:0]          push_oob_s;
  logic [PD-1:0][FETCH_WIDTH-1:0]  pipe_oob_q, pipe_oob_d;
  logic [QUEUE_DEPTH-1:0]          q_err_q, q_err_d;
`endif

  // The low address bits select the byte within a word and are ignored.
  // Without the range check, the bits above the index are also ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_req_packet, load_addr};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Ready looks only at state, flush and reset, never at imem_req_val.
  assign imem_req_rdy = rst & ~flush & (occ_q < CW'(QUEUE_DEPTH));
  assign fire_req_s   = imem_req_val & imem_req_rdy;
  assign imem_rec_val = (q_cnt_q != '0);
  assign fire_rec_s   = imem_rec_val & imem_rec_rdy;
  // Zero while empty, so reset and flush present an all-zero packet.
  assign imem_rec_packet = imem_rec_val ? q_data_q[rd_ptr_q] : '0;
`ifdef IMEM_OOB_ERR_EN
  assign imem_rec_err = imem_rec_val & q_err_q[rd_ptr_q];
`endif

  assign req_idx_s = imem_req_packet[AW+1:2];

`ifdef IMEM_OOB_ERR_EN
  // Per-lane out-of-range flags, computed on the full word address at
  // acceptance time so the upper address bits need not be pipelined.
  always_comb begin
    logic [CPU_ADDR_BITS-1:0] word_v;
    req_oob_s = '0;
    word_v    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      word_v = CPU_ADDR_BITS'(imem_req_packet[CPU_ADDR_BITS-1:2]) + CPU_ADDR_BITS'(i);
      if (word_v >= CPU_ADDR_BITS'(DEPTH_WORDS)) begin
        req_oob_s[i] = 1'b1;
      end else begin
        req_oob_s[i] = 1'b0;
      end
    end
  end
`endif

  // Occupancy counter: the number of accepted fetches not yet popped.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (fire_req_s && !fire_rec_s) begin
      occ_d = occ_q + CW'(1);
    end else if (!fire_req_s && fire_rec_s) begin
      occ_d = occ_q - CW'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline
  // ---------------------------------------------------------------------------
  // Shift the {valid, index} pipeline; flush kills every stage.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_idx_d[0] = req_idx_s;
    for (int s = 1; s < PD; s++) begin
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end
    if (flush) begin
      pipe_vld_d = '0;
    end else begin
      pipe_vld_d[0] = fire_req_s;
      for (int s = 1; s < PD; s++) begin
        pipe_vld_d[s] = pipe_vld_q[s-1];
      end
    end
  end

`ifdef IMEM_OOB_ERR_EN
  // Carry the lane out-of-range flags alongside the index.
  always_comb begin
    pipe_oob_d    = pipe_oob_q;
    pipe_oob_d[0] = req_oob_s;
    for (int s = 1; s < PD; s++) begin
      pipe_oob_d[s] = pipe_oob_q[s-1];
    end
  end
`endif

  generate
    if (LATENCY > 1) begin : g_pipe_out
      assign push_vld_s = pipe_vld_q[PD-1];
      assign push_idx_s = pipe_idx_q[PD-1];
`ifdef IMEM_OOB_ERR_EN
      assign push_oob_s = pipe_oob_q[PD-1];
`endif
    end else begin : g_no_pipe
      assign push_vld_s = fire_req_s;
      assign push_idx_s = req_idx_s;
`ifdef IMEM_OOB_ERR_EN
      assign push_oob_s = req_oob_s;
`endif
    end
  endgenerate

  // A fetch still in the pipeline at a flush edge is dropped.
  assign push_s = push_vld_s & ~flush;

  // Read the lanes at the push edge. The index sum wraps naturally because
  // AW bits span exactly DEPTH_WORDS. A load on the same edge is not seen.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
`ifdef IMEM_OOB_ERR_EN
      if (push_oob_s[i]) begin
        rd_data_s[i*CPU_INST_BITS +: CPU_INST_BITS] = NOP_INST;
      end else begin
        rd_data_s[i*CPU_INST_BITS +: CPU_INST_BITS] = mem_q[push_idx_s + AW'(i)];
      end
`else
      rd_data_s[i*CPU_INST_BITS +: CPU_INST_BITS] = mem_q[push_idx_s + AW'(i)];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Response queue
  // ---------------------------------------------------------------------------
  // Update the FIFO pointers, count and data. Push and pop are both allowed
  // when the queue is full.
  always_comb begin
    q_data_d = q_data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_cnt_d  = q_cnt_q;
`ifdef IMEM_OOB_ERR_EN
    q_err_d  = q_err_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      q_cnt_d  = '0;
    end else begin
      if (push_s) begin
        q_data_d[wr_ptr_q] = rd_data_s;
`ifdef IMEM_OOB_ERR_EN
        q_err_d[wr_ptr_q]  = |push_oob_s;
`endif
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (fire_rec_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, fire_rec_s})
        2'b10:   q_cnt_d = q_cnt_q + CW'(1);
        2'b01:   q_cnt_d = q_cnt_q - CW'(1);
        default: q_cnt_d = q_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control state. Reset drops every outstanding fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_cnt_q    <= q_cnt_d;
    end
  end

`ifdef IMEM_OOB_ERR_EN
  // Error flags for the out-of-range feature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_oob_q <= '0;
      q_err_q    <= '0;
    end else begin
      pipe_oob_q <= pipe_oob_d;
      q_err_q    <= q_err_d;
    end
  end
`endif

  // Datapath registers. They are qualified by the valids or the count, so
  // they need no reset.
  always_ff @(posedge clk) begin
    pipe_idx_q <= pipe_idx_d;
    q_data_q   <= q_data_d;
  end

  // Backing-store write port. It is independent of the fetch handshake.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_addr[AW+1:2]] <= load_data;
    end
  end

endmodule
